// File: rtl/mux_2to1_pkg.sv
// Shared constants and helpers for the clocked 2:1 selector.
// Provides the input-stage bundle width: {sel, in1, in2}.
package mux_2to1_pkg;

    // The select line travels with the data through the input stage.
    localparam int SEL_BITS = 1;

    // Width of the packed {sel, in1, in2} bundle for a data width w.
    function automatic int in_stage_width(input int w);
        return 2 * w + SEL_BITS;
    endfunction

endpackage

// File: rtl/mux_pipe_reg.sv
// Generic WIDTH-bit pipeline register, sync active-low clear, bypassable.
// Ports: i_clk, i_rst_n (sync, active-low), i_d (data in), o_q (data out).
module mux_pipe_reg #(
    parameter int WIDTH  = 1,
    parameter bit BYPASS = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (BYPASS) begin : g_bypass
            // Pure wire: clock and reset have no effect in this build.
            assign o_q = i_d;
        end else begin : g_reg
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_q <= '0;
                end else begin
                    r_q <= i_d;
                end
            end

            assign o_q = r_q;
        end
    endgenerate

endmodule

// File: rtl/mux_2to1.sv
// Clocked 2:1 selector: out = sel ? in1 : in2, with optional in/out stages.
// Ports: sys_clk, sys_rst_n (sync, active-low), in1, in2, sel, out.
module mux_2to1
    import mux_2to1_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int IN_REG  = 1,
    parameter int OUT_REG = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    localparam int IW = in_stage_width(WIDTH);

    logic [IW-1:0]    w_in_d;
    logic [IW-1:0]    w_in_q;
    logic             w_sel_s;
    logic [WIDTH-1:0] w_in1_s;
    logic [WIDTH-1:0] w_in2_s;
    logic [WIDTH-1:0] w_mux;

    // sel is staged together with the data so that a sel change and a
    // data change presented in the same cycle take effect together.
    assign w_in_d = {sel, in1, in2};

    mux_pipe_reg #(
        .WIDTH (IW),
        .BYPASS(IN_REG == 0)
    ) u_in_stage (
        .i_clk  (sys_clk),
        .i_rst_n(sys_rst_n),
        .i_d    (w_in_d),
        .o_q    (w_in_q)
    );

    assign w_sel_s = w_in_q[IW-1];
    assign w_in1_s = w_in_q[2*WIDTH-1:WIDTH];
    assign w_in2_s = w_in_q[WIDTH-1:0];

    // A known sel blocks X on the unselected input.
    assign w_mux = w_sel_s ? w_in1_s : w_in2_s;

    mux_pipe_reg #(
        .WIDTH (WIDTH),
        .BYPASS(OUT_REG == 0)
    ) u_out_stage (
        .i_clk  (sys_clk),
        .i_rst_n(sys_rst_n),
        .i_d    (w_mux),
        .o_q    (out)
    );

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: scoreboard on the default build
// plus directed checks on a combinational WIDTH=8 build.
module tb_mux_2to1;

    logic       clk;
    logic       rst_n;
    logic [0:0] in1;
    logic [0:0] in2;
    logic       sel;
    logic [0:0] out;

    logic [7:0] c_in1;
    logic [7:0] c_in2;
    logic       c_sel;
    logic [7:0] c_out;

    int n_chk = 0;
    int n_err = 0;

    logic [0:0] sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_2to1 #(
        .WIDTH  (1),
        .IN_REG (1),
        .OUT_REG(1)
    ) u_dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .in1      (in1),
        .in2      (in2),
        .sel      (sel),
        .out      (out)
    );

    mux_2to1 #(
        .WIDTH  (8),
        .IN_REG (0),
        .OUT_REG(0)
    ) u_comb (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .in1      (c_in1),
        .in2      (c_in2),
        .sel      (c_sel),
        .out      (c_out)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: each edge, a reset edge clears history and leaves a
    // cleared input-stage value queued; a run edge pops the value due
    // now and queues the result for the inputs just sampled.
    always @(posedge clk) begin
        logic [0:0] e;
        logic [0:0] f;
        logic       r;
        r = rst_n;
        f = sel ? in1 : in2;
        if (!r) begin
            sb_q.delete();
            sb_q.push_back(1'b0);
            e = 1'b0;
        end else begin
            if (sb_q.size() == 0) begin
                e = 1'bx;
            end else begin
                e = sb_q.pop_front();
            end
            sb_q.push_back(f);
        end
        #1;
        if (r && e === 1'bx) begin
            chk("sb_empty", 8'(out), 8'hFF);
        end else begin
            chk(r ? "sb" : "sb_rst", 8'(out), 8'(e));
        end
    end

    task automatic drive(input logic a, input logic b, input logic s,
                         input int n);
        in1 = a;
        in2 = b;
        sel = s;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in1 = 1'b1;
        in2 = 1'b1;
        sel = 1'b1;
        c_in1 = 8'h00;
        c_in2 = 8'h00;
        c_sel = 1'b0;

        // Reset held 3 cycles with all inputs high: out stays 0.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Select in1, then switch to in2.
        drive(1'b1, 1'b0, 1'b1, 4);
        drive(1'b1, 1'b0, 1'b0, 4);

        // Equal inputs with sel toggling every cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, i[0], 1);
        end

        // Alternating sources with sel toggling every cycle.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, i[0], 1);
        end

        // X on the unselected input must not reach out.
        drive(1'b1, 1'bx, 1'b1, 3);
        drive(1'bx, 1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b0, 3);

        // Random traffic with a one-cycle reset in the middle.
        for (int i = 0; i < 200; i++) begin
            in1 = 1'($urandom_range(0, 1));
            in2 = 1'($urandom_range(0, 1));
            sel = 1'($urandom_range(0, 1));
            rst_n = (i == 100) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Combinational build: result visible without a clock edge.
        c_in1 = 8'hA5;
        c_in2 = 8'h3C;
        c_sel = 1'b0;
        #1 chk("comb_sel0", c_out, 8'h3C);
        c_sel = 1'b1;
        #1 chk("comb_sel1", c_out, 8'hA5);
        c_in1 = 8'h5A;
        #1 chk("comb_in1_chg", c_out, 8'h5A);
        c_in2 = 8'h5A;
        c_sel = 1'b0;
        #1 chk("comb_equal", c_out, 8'h5A);
        c_in1 = 8'hFF;
        c_in2 = 8'h00;
        #1 chk("comb_zero", c_out, 8'h00);
        c_sel = 1'b1;
        #1 chk("comb_ones", c_out, 8'hFF);
        c_in2 = 8'hxx;
        #1 chk("comb_x_unsel", c_out, 8'hFF);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
